reg_file: RTL and testbench

- MIPS integer register file: 32 x 32-bit GPRs plus HI/LO pair. Sits directly upstream of the ALU.
- read_data1 drives the ALU's first operand (A); read_data2 drives its second operand (directly, or via the ALU_Src mux).
- The writeback stage writes results back through a single write port.
- HI/LO hold the 64-bit product for mult/mfhi/mflo.

---
 rtl/reg_file.sv | 69 ++++++
 tb/tb_reg_file.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// reg_file: MIPS 32x32 GPR file with HI/LO pair, debug read port and write counter.
// Define REG_FILE_BYPASS_EN for write-first bypass on read_data1/2 and hi_out/lo_out.
module reg_file #(
  parameter logic [31:0] SP_INIT = 32'h0000_3FFC,
  parameter logic [31:0] GP_INIT = 32'h0000_1800,
  parameter int          DBG_EN  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  read_reg1,
  input  logic [4:0]  read_reg2,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2,
  input  logic        reg_write,
  input  logic [4:0]  write_reg,
  input  logic [31:0] write_data,
  input  logic        hilo_write,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  input  logic [4:0]  dbg_reg,
  output logic [31:0] dbg_data,
  output logic [15:0] write_count
);
  logic [31:0] gpr_q [32];
  logic [31:0] gpr_d [32];
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [15:0] wc_q, wc_d;
  logic        gpr_we, hilo_we;
  always_comb begin
    gpr_we  = reg_write && !reset && write_reg != 5'd0;
    hilo_we = hilo_write && !reset;
    gpr_d   = gpr_q;
    if (gpr_we) gpr_d[write_reg] = write_data;
    wc_d = wc_q + {15'd0, gpr_we};
    hi_d = hilo_we ? hi_in : hi_q;
    lo_d = hilo_we ? lo_in : lo_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++)
        gpr_q[i] <= (i == 28) ? GP_INIT : (i == 29) ? SP_INIT : 32'h0;
      hi_q <= '0;
      lo_q <= '0;
      wc_q <= '0;
    end else begin
      gpr_q <= gpr_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      wc_q  <= wc_d;
    end
  end
  always_comb begin
`ifdef REG_FILE_BYPASS_EN
    read_data1 = (read_reg1 == 5'd0) ? '0 : (gpr_we && write_reg == read_reg1) ? write_data : gpr_q[read_reg1];
    read_data2 = (read_reg2 == 5'd0) ? '0 : (gpr_we && write_reg == read_reg2) ? write_data : gpr_q[read_reg2];
    hi_out     = hilo_we ? hi_in : hi_q;
    lo_out     = hilo_we ? lo_in : lo_q;
`else
    read_data1 = (read_reg1 == 5'd0) ? '0 : gpr_q[read_reg1];
    read_data2 = (read_reg2 == 5'd0) ? '0 : gpr_q[read_reg2];
    hi_out     = hi_q;
    lo_out     = lo_q;
`endif
    dbg_data    = (DBG_EN == 0 || dbg_reg == 5'd0) ? '0 : gpr_q[dbg_reg];
    write_count = wc_q;
  end
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed scoreboard bench for reg_file.
module tb_reg_file;
  logic        clk = 0;
  logic        reset;
  logic [4:0]  read_reg1, read_reg2, write_reg, dbg_reg;
  logic [31:0] read_data1, read_data2, write_data, hi_in, lo_in, hi_out, lo_out, dbg_data;
  logic        reg_write, hilo_write;
  logic [15:0] write_count;
  int n_cmp = 0, n_bad = 0;

  typedef struct {int sel; logic [31:0] exp; string name;} chk_t;
  chk_t q[$];

  reg_file dut (
    .clk(clk), .reset(reset),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(read_data1), .read_data2(read_data2),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .hilo_write(hilo_write), .hi_in(hi_in), .lo_in(lo_in),
    .hi_out(hi_out), .lo_out(lo_out),
    .dbg_reg(dbg_reg), .dbg_data(dbg_data), .write_count(write_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] out_of(int sel);
    case (sel)
      0: return read_data1;
      1: return read_data2;
      2: return hi_out;
      3: return lo_out;
      4: return dbg_data;
      default: return {16'h0, write_count};
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    chk_t c;
    logic [31:0] a;
    while (q.size() > 0) begin
      c = q.pop_front();
      a = out_of(c.sel);
      n_cmp++;
      if (a !== c.exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", c.name, a, c.exp);
      end
    end
  end

  task automatic expect_out(int sel, logic [31:0] e, string n);
    chk_t c;
    c.sel = sel; c.exp = e; c.name = n;
    q.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; reg_write = 0; hilo_write = 0;
  endtask

  initial begin
    logic [31:0] e;
    reset = 1; reg_write = 0; hilo_write = 0;
    read_reg1 = 0; read_reg2 = 0; write_reg = 0; dbg_reg = 0;
    write_data = 0; hi_in = 0; lo_in = 0;
    tick(); tick();
    idle();
    // reset contents of every index
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i); dbg_reg = 5'(i);
      e = (i == 28) ? 32'h0000_1800 : (i == 29) ? 32'h0000_3FFC : 32'h0;
      expect_out(0, e, $sformatf("reset_rd1_%0d", i));
      expect_out(4, e, $sformatf("reset_dbg_%0d", i));
      if (i == 0) begin
        expect_out(2, 32'h0, "reset_hi");
        expect_out(3, 32'h0, "reset_lo");
        expect_out(5, 32'h0, "reset_wc");
      end
      tick();
    end
    // $5 write then dual same-index read
    reg_write = 1; write_reg = 5; write_data = 32'hDEAD_BEEF;
    tick();
    idle(); read_reg1 = 5; read_reg2 = 5; dbg_reg = 5;
    expect_out(0, 32'hDEAD_BEEF, "w5_rd1");
    expect_out(1, 32'hDEAD_BEEF, "w5_rd2");
    expect_out(4, 32'hDEAD_BEEF, "w5_dbg");
    expect_out(5, 32'd1, "w5_wc");
    tick();
    // $0 write is ignored
    reg_write = 1; write_reg = 0; write_data = 32'hFFFF_FFFF;
    read_reg1 = 0; read_reg2 = 0; dbg_reg = 0;
    expect_out(0, 32'h0, "w0_same_rd1");
    expect_out(1, 32'h0, "w0_same_rd2");
    tick();
    idle();
    expect_out(0, 32'h0, "w0_rd1");
    expect_out(1, 32'h0, "w0_rd2");
    expect_out(4, 32'h0, "w0_dbg");
    expect_out(5, 32'd1, "w0_wc");
    tick();
    // same-cycle read/write of $7
    reg_write = 1; write_reg = 7; write_data = 32'h1234; read_reg2 = 7; dbg_reg = 7;
`ifdef REG_FILE_BYPASS_EN
    expect_out(1, 32'h1234, "w7_same_rd2");
`else
    expect_out(1, 32'h0, "w7_same_rd2");
`endif
    expect_out(4, 32'h0, "w7_same_dbg");
    tick();
    idle();
    expect_out(1, 32'h1234, "w7_next_rd2");
    expect_out(4, 32'h1234, "w7_next_dbg");
    expect_out(5, 32'd2, "w7_wc");
    tick();
    // reset wins over simultaneous writes
    reset = 1; reg_write = 1; write_reg = 3; write_data = 32'h55;
    hilo_write = 1; hi_in = 1; lo_in = 2;
    tick();
    idle(); read_reg1 = 3; read_reg2 = 5;
    expect_out(0, 32'h0, "rst_wr_r3");
    expect_out(1, 32'h0, "rst_wr_r5");
    expect_out(2, 32'h0, "rst_wr_hi");
    expect_out(3, 32'h0, "rst_wr_lo");
    expect_out(5, 32'h0, "rst_wr_wc");
    tick();
    // write_count wrap
    reg_write = 1; write_reg = 9;
    for (int i = 0; i < 65537; i++) begin
      write_data = i;
      tick();
    end
    idle(); read_reg1 = 9;
    expect_out(5, 32'h1, "wrap_wc");
    expect_out(0, 32'h0001_0000, "wrap_r9");
    tick();
    // HI/LO write
    hilo_write = 1; hi_in = 32'h1; lo_in = 32'h8000_0000;
`ifdef REG_FILE_BYPASS_EN
    expect_out(2, 32'h1, "hilo_same_hi");
    expect_out(3, 32'h8000_0000, "hilo_same_lo");
`else
    expect_out(2, 32'h0, "hilo_same_hi");
    expect_out(3, 32'h0, "hilo_same_lo");
`endif
    tick();
    idle(); hi_in = 0; lo_in = 0;
    expect_out(2, 32'h1, "hilo_hi");
    expect_out(3, 32'h8000_0000, "hilo_lo");
    expect_out(5, 32'h1, "hilo_wc");
    tick();
    tick();
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
